// File: rtl/score_display.sv
// score_display: four-digit multiplexed seven-segment driver for two
// two-digit BCD scores (player 1 on the left pair, player 2 on the right
// pair, decimal point after digit 1 as the separator).
//
// Optional feature macro: SCORE_DISPLAY_FLASH_EN
//   defined   - each player's digits flash (blank/show) for FLASH_COUNT
//               pairs of FLASH_DIV-cycle half-periods after that player's
//               captured score changes.
//   undefined - no flash logic; FLASH_DIV and FLASH_COUNT are ignored.
//
// Pipeline: inputs -> capture regs -> registered seg/an/dp, so an input
// change is visible on seg two edges after it is applied (when that digit
// is being scanned).
//
// Interface protocol: there is no handshake. Scores are sampled on every
// rising clk edge with no valid/ready qualification; the display simply
// follows whatever the upstream counter presents.

module score_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int FLASH_DIV   = 25000000,
  parameter int FLASH_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] big1,
  input  logic [3:0] sm1,
  input  logic [3:0] big2,
  input  logic [3:0] sm2,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_DASH;
    case (v)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Capture registers
  logic [3:0] big1_q, big1_d;
  logic [3:0] sm1_q,  sm1_d;
  logic [3:0] big2_q, big2_d;
  logic [3:0] sm2_q,  sm2_d;

  // Scan sequencing
  logic [RW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;

  // Registered outputs
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q,  an_d;
  logic       dp_q,  dp_d;

  // Per-player flash blanking request (always low without the feature)
  logic blank_p1;
  logic blank_p2;

  // Capture every cycle; all decode works from the captured copy.
  always_comb begin
    big1_d = big1;
    sm1_d  = sm1;
    big2_d = big2;
    sm2_d  = sm2;
  end

  // Refresh counter and digit index: advance the index on terminal count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == REF_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Digit select, leading-zero / flash blanking and segment decode.
  always_comb begin
    logic [3:0] digit_val;
    logic       digit_blank;
    an_d        = 4'b1111;
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    case (idx_q)
      2'd0: begin
        an_d        = 4'b0111;
        digit_val   = big1_q;
        digit_blank = (big1_q == 4'd0) || blank_p1;
      end
      2'd1: begin
        an_d        = 4'b1011;
        digit_val   = sm1_q;
        digit_blank = blank_p1;
      end
      2'd2: begin
        an_d        = 4'b1101;
        digit_val   = big2_q;
        digit_blank = (big2_q == 4'd0) || blank_p2;
      end
      default: begin
        an_d        = 4'b1110;
        digit_val   = sm2_q;
        digit_blank = blank_p2;
      end
    endcase
    seg_d = digit_blank ? SEG_OFF : seg_decode(digit_val);
    // Separator point only on player 1's units digit, and only when lit.
    dp_d  = digit_blank || (idx_q != 2'd1);
  end

  // Main register bank with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      big1_q <= 4'd0;
      sm1_q  <= 4'd0;
      big2_q <= 4'd0;
      sm2_q  <= 4'd0;
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      seg_q  <= SEG_OFF;
      an_q   <= 4'b1111;
      dp_q   <= 1'b1;
    end else begin
      big1_q <= big1_d;
      sm1_q  <= sm1_d;
      big2_q <= big2_d;
      sm2_q  <= sm2_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
    end
  end

`ifdef SCORE_DISPLAY_FLASH_EN

  localparam int REM_INIT = 2 * FLASH_COUNT;
  localparam int REM_W    = (REM_INIT > 1) ? $clog2(REM_INIT + 1) : 1;
  localparam int FW       = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(REM_INIT);
  localparam logic [FW-1:0]    FL_LAST  = FW'(FLASH_DIV - 1);

  // primed_q masks the first capture after reset: loading the current
  // score out of a cleared register is not a score change.
  logic             primed_q, primed_d;
  logic [REM_W-1:0] rem1_q, rem1_d;
  logic [REM_W-1:0] rem2_q, rem2_d;
  logic [FW-1:0]    tmr1_q, tmr1_d;
  logic [FW-1:0]    tmr2_q, tmr2_d;
  logic             chg1, chg2;

  // Change detect and flash countdown, independently per player.
  always_comb begin
    primed_d = 1'b1;
    chg1     = primed_q && ({big1, sm1} != {big1_q, sm1_q});
    chg2     = primed_q && ({big2, sm2} != {big2_q, sm2_q});
    rem1_d   = rem1_q;
    tmr1_d   = tmr1_q;
    rem2_d   = rem2_q;
    tmr2_d   = tmr2_q;
    if (chg1) begin
      rem1_d = REM_LOAD;
      tmr1_d = '0;
    end else if (rem1_q != '0) begin
      if (tmr1_q == FL_LAST) begin
        tmr1_d = '0;
        rem1_d = rem1_q - 1'b1;
      end else begin
        tmr1_d = tmr1_q + 1'b1;
      end
    end
    if (chg2) begin
      rem2_d = REM_LOAD;
      tmr2_d = '0;
    end else if (rem2_q != '0) begin
      if (tmr2_q == FL_LAST) begin
        tmr2_d = '0;
        rem2_d = rem2_q - 1'b1;
      end else begin
        tmr2_d = tmr2_q + 1'b1;
      end
    end
  end

  // Flash state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      primed_q <= 1'b0;
      rem1_q   <= '0;
      tmr1_q   <= '0;
      rem2_q   <= '0;
      tmr2_q   <= '0;
    end else begin
      primed_q <= primed_d;
      rem1_q   <= rem1_d;
      tmr1_q   <= tmr1_d;
      rem2_q   <= rem2_d;
      tmr2_q   <= tmr2_d;
    end
  end

  // Even non-zero remainder = blank half, so each flash starts dark.
  assign blank_p1 = (rem1_q != '0) && !rem1_q[0];
  assign blank_p2 = (rem2_q != '0) && !rem2_q[0];

`else

  logic unused_flash_cfg;
  assign unused_flash_cfg = (FLASH_DIV > 0) ^ (FLASH_COUNT > 0);
  assign blank_p1 = 1'b0;
  assign blank_p2 = 1'b0;

`endif

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: reset/release, vector table, scan timing,
// reset mid-scan, optional flash sequences and randomized scores against
// a cycle-counting reference model.

module tb_score_display;

  localparam int R = 4;
  localparam int F = 8;
  localparam int C = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] big1 = 4'd0;
  logic [3:0] sm1  = 4'd0;
  logic [3:0] big2 = 4'd0;
  logic [3:0] sm2  = 4'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  always #5 clk = ~clk;

  score_display #(.REFRESH_DIV(R), .FLASH_DIV(F), .FLASH_COUNT(C)) dut (
    .clk  (clk),
    .reset(reset),
    .big1 (big1),
    .sm1  (sm1),
    .big2 (big2),
    .sm2  (sm2),
    .seg  (seg),
    .dp   (dp),
    .an   (an)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [16];
  int         n_edge;          // edges since reset release
  logic [3:0] cap [4];         // captured {big1, sm1, big2, sm2}
  int         last_chg [2];    // edge at which a player's change was captured
  logic [6:0] m_seg;
  logic       m_dp;
  logic [3:0] m_an;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual={an,seg,dp}=%b expected=%b", name, n_edge, act, exp);
    end
  endtask

  // Flash state of player p after edge m, from elapsed time since change.
  function automatic logic flash_blank(input int p, input int m);
    int k;
    int r;
    if (last_chg[p] < 0) return 1'b0;
    k = m - last_chg[p];
    r = 2 * C - k / F;
    if (r < 0) r = 0;
    return (r != 0) && (r % 2 == 0);
  endfunction

  task automatic model_edge();
    logic [3:0] ins [4];
    int         d;
    logic       blank;
    ins = '{big1, sm1, big2, sm2};
    if (!reset) begin
      n_edge   = 0;
      cap      = '{4'd0, 4'd0, 4'd0, 4'd0};
      last_chg = '{-1, -1};
      m_an     = 4'hF;
      m_seg    = 7'h7F;
      m_dp     = 1'b1;
      return;
    end
    n_edge++;
    d     = ((n_edge - 1) / R) % 4;
    blank = flash_blank(d / 2, n_edge - 1);
    if ((d == 0 || d == 2) && cap[d] == 4'd0) blank = 1'b1;
    m_an        = 4'hF;
    m_an[3 - d] = 1'b0;
    m_seg       = blank ? 7'h7F : seg_tab[cap[d]];
    m_dp        = !(d == 1 && !blank);
`ifdef SCORE_DISPLAY_FLASH_EN
    for (int p = 0; p < 2; p++)
      if (n_edge >= 2 && {ins[2*p], ins[2*p+1]} != {cap[2*p], cap[2*p+1]})
        last_chg[p] = n_edge;
`endif
    cap = ins;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("scan", {an, seg, dp}, {m_an, m_seg, m_dp});
  endtask

  task automatic set_scores(input logic [3:0] b1, input logic [3:0] s1,
                            input logic [3:0] b2, input logic [3:0] s2);
    big1 = b1;
    sm1  = s1;
    big2 = b2;
    sm2  = s2;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) step();
    check("reset_state", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  b1, s1, b2, s2;
    logic [27:0] segs;   // expected seg for digits 0,1,2,3 (MSB first)
  } vec_t;

  vec_t vecs [6];

  initial begin
    int   found;
    logic [3:0] prev_an;
    logic [3:0] exp_an [4];
    int   d;

    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    n_edge   = 0;
    cap      = '{4'd0, 4'd0, 4'd0, 4'd0};
    last_chg = '{-1, -1};
    exp_an   = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4,  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd0,  {7'b1111111, 7'b1000000, 7'b1111111, 7'b1000000}};
    vecs[2] = '{4'd1, 4'd2, 4'd3, 4'hA,  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0111111}};
    vecs[3] = '{4'd5, 4'd6, 4'd0, 4'd7,  {7'b0010010, 7'b0000010, 7'b1111111, 7'b1111000}};
    vecs[4] = '{4'd9, 4'd8, 4'hF, 4'd9,  {7'b0010000, 7'b0000000, 7'b0111111, 7'b0010000}};
    vecs[5] = '{4'd0, 4'd9, 4'd7, 4'd0,  {7'b1111111, 7'b0010000, 7'b1111000, 7'b1000000}};

    // Reset and release with all scores zero.
    set_scores(4'd0, 4'd0, 4'd0, 4'd0);
    do_reset(5);
    step();
    check("release_d0", {an, seg, dp}, {4'b0111, 7'b1111111, 1'b1});
    repeat (3) step();
    step();
    check("release_d1", {an, seg, dp}, {4'b1011, 7'b1000000, 1'b0});

    // Table-driven decode: settle past any flash, then check one frame.
    for (int v = 0; v < 6; v++) begin
      set_scores(vecs[v].b1, vecs[v].s1, vecs[v].b2, vecs[v].s2);
      repeat (40) step();
      for (int i = 0; i < 4 * R; i++) begin
        step();
        d = -1;
        for (int j = 0; j < 4; j++) if (an == exp_an[j]) d = j;
        if (d < 0) begin
          check("vec_an", {an, seg, dp}, {exp_an[0], vecs[v].segs[27 -: 7], 1'b1});
        end else begin
          check("vec_seg", {an, seg, dp},
                {exp_an[d], vecs[v].segs[27 - 7*d -: 7], (d == 1) ? 1'b0 : 1'b1});
        end
      end
    end

    // Scan timing for 12 / 34: each enable held exactly R cycles.
    set_scores(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (40) step();
    found   = 0;
    prev_an = an;
    for (int i = 0; i < 4 * R + 2 && found == 0; i++) begin
      step();
      if (an == 4'b0111 && prev_an != 4'b0111) found = 1;
      prev_an = an;
    end
    if (found == 0) begin
      check("frame_start", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
    end else begin
      for (int i = 1; i < 4 * R; i++) begin
        step();
        check("hold", {an, 8'h00}, {exp_an[i / R], 8'h00});
      end
    end

    // Reset mid-scan returns to the reset state on the same edge.
    repeat (6) step();
    reset = 1'b0;
    step();
    check("reset_mid_scan", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    reset = 1'b1;
    repeat (20) step();

`ifdef SCORE_DISPLAY_FLASH_EN
    // Flash on sm1 0->1, restarted by a second change 5 cycles later.
    set_scores(4'd0, 4'd0, 4'd0, 4'd0);
    do_reset(3);
    repeat (12) step();
    sm1 = 4'd1;
    repeat (5) step();
    sm1 = 4'd2;
    repeat (70) step();
    // 99 -> 00 wrap on player 1 together with a player 2 change.
    set_scores(4'd9, 4'd9, 4'd1, 4'd1);
    repeat (70) step();
    set_scores(4'd0, 4'd0, 4'd1, 4'd2);
    repeat (70) step();
    // Reset during the blank phase, then no flashing after release.
    sm1 = 4'd3;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_mid_flash", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    step();
    reset = 1'b1;
    repeat (60) step();
`endif

    // Randomized scores with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_scores(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                   4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
      reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset = 1'b1;
    repeat (8) step();

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
